// File: rtl/prediction_writer_pkg.sv
// Shared definitions for the prediction write-back path: data sizes and FSM state encoding.
package prediction_writer_pkg;

  localparam int PREDICTION_DATA_SIZE = 8;
  localparam int SAMPLE_DATA_SIZE     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pw_state_e;

endpackage

// File: rtl/prediction_writer_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; flush empties it in one cycle.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/prediction_writer.sv
// Accepts model predictions over valid/ready, buffers them and writes them to consecutive
// result-memory addresses; reports completion once the last beat has been committed.
module prediction_writer
  import prediction_writer_pkg::*;
#(
  parameter int OUT_W     = PREDICTION_DATA_SIZE,
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pred_valid,
  input  logic [OUT_W-1:0]  pred_data,
  input  logic              pred_last,
  output logic              pred_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [OUT_W-1:0]  mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LP_LAST = '1;

  pw_state_e         r_state;
  pw_state_e         w_state_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [OUT_W:0]    w_fifo_rdata;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_addr_spent;
  logic              r_last_popped;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [OUT_W-1:0]  r_mem_wdata;
  logic [ADDR_W:0]   r_count;
  logic              r_done;
  logic              r_overflow;

  // start aborts the session, so it blocks both the accept and the pop of that cycle.
  assign pred_ready = (r_state == ST_RUN) & ~w_fifo_full;
  assign w_push     = pred_valid & pred_ready & ~start;
  assign w_pop      = ~w_fifo_empty & ~start;
  assign busy       = (r_state == ST_RUN) | (r_state == ST_DRAIN);

  sync_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (start),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({pred_last, pred_data}),
    .o_data  (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:   if (w_push && pred_last) w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (w_fifo_empty && !r_mem_we && r_last_popped) w_state_nxt = ST_DONE;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  // Write stage: one popped entry per cycle; entries past the top address are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we      <= 1'b0;
      r_mem_addr    <= LP_BASE;
      r_mem_wdata   <= '0;
      r_wr_addr     <= LP_BASE;
      r_addr_spent  <= 1'b0;
      r_last_popped <= 1'b0;
      r_count       <= '0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
    end else if (start) begin
      r_mem_we      <= 1'b0;
      r_mem_addr    <= LP_BASE;
      r_wr_addr     <= LP_BASE;
      r_addr_spent  <= 1'b0;
      r_last_popped <= 1'b0;
      r_count       <= '0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_pop) begin
        if (w_fifo_rdata[OUT_W]) r_last_popped <= 1'b1;
        if (r_addr_spent) begin
          r_overflow <= 1'b1;
        end else begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_wr_addr;
          r_mem_wdata <= w_fifo_rdata[OUT_W-1:0];
          r_wr_addr   <= r_wr_addr + 1'b1;
          r_count     <= r_count + 1'b1;
          if (r_wr_addr == LP_LAST) r_addr_spent <= 1'b1;
        end
      end
      if (r_state == ST_DRAIN && w_state_nxt == ST_DONE) r_done <= 1'b1;
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign count     = r_count;
  assign done      = r_done;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_prediction_writer.sv
// Randomized and directed bench for prediction_writer against a queue-based reference model.
module tb_prediction_writer;

  localparam int OUT_W     = 8;
  localparam int ADDR_W    = 3;
  localparam int DEPTH     = 4;
  localparam int BASE_ADDR = 0;
  localparam int NADDR     = 1 << ADDR_W;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              pred_valid = 1'b0;
  logic [OUT_W-1:0]  pred_data = '0;
  logic              pred_last = 1'b0;
  logic              pred_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [OUT_W-1:0]  mem_wdata;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   count;

  prediction_writer #(
    .OUT_W     (OUT_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pred_valid (pred_valid),
    .pred_data  (pred_data),
    .pred_last  (pred_last),
    .pred_ready (pred_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .count      (count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: session mode, queue of buffered beats, expected write-port contents.
  int                m_mode = M_IDLE;
  logic [OUT_W:0]    m_q[$];
  bit                m_we = 1'b0;
  int                m_addr = BASE_ADDR;
  logic [OUT_W-1:0]  m_data = '0;
  int                m_written = 0;
  bit                m_ovf = 1'b0;
  bit                m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int             occ;
    bit             prev_we;
    bit             acc;
    logic [OUT_W:0] item;
    if (!rst_n) begin
      m_q.delete();
      m_mode = M_IDLE; m_we = 1'b0; m_addr = BASE_ADDR; m_data = '0;
      m_written = 0; m_ovf = 1'b0; m_done = 1'b0;
    end else begin
      occ     = m_q.size();
      prev_we = m_we;
      acc     = pred_valid && (m_mode == M_RUN) && (occ < DEPTH);
      if (start) begin
        m_q.delete();
        m_we = 1'b0; m_written = 0; m_ovf = 1'b0; m_done = 1'b0; m_mode = M_RUN;
      end else begin
        m_we = 1'b0;
        if (occ > 0) begin
          item = m_q.pop_front();
          if (m_written < NADDR) begin
            m_we      = 1'b1;
            m_addr    = BASE_ADDR + m_written;
            m_data    = item[OUT_W-1:0];
            m_written = m_written + 1;
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (m_mode == M_DRAIN && occ == 0 && !prev_we) begin
          m_mode = M_DONE;
          m_done = 1'b1;
        end
        if (acc) begin
          m_q.push_back({pred_last, pred_data});
          if (pred_last) m_mode = M_DRAIN;
        end
      end
    end
  end

  bit chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("pred_ready", pred_ready, (m_mode == M_RUN) && (m_q.size() < DEPTH));
      chk("busy", busy, (m_mode == M_RUN) || (m_mode == M_DRAIN));
      chk("mem_we", mem_we, m_we);
      if (m_we) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_data);
      end
      chk("count", count, m_written);
      chk("done", done, m_done);
      chk("overflow", overflow, m_ovf);
    end
  end

  logic [ADDR_W+OUT_W-1:0] wlog[$];

  always @(posedge clk) begin
    if (rst_n && mem_we) wlog.push_back({mem_addr, mem_wdata});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int n, input logic [OUT_W-1:0] d0, input bit rnd,
                      input int gap_pct, input bit with_last);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int waited;
      for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
        pred_valid = 1'b0;
        tick();
      end
      pred_valid = 1'b1;
      pred_data  = rnd ? OUT_W'($urandom) : d0 + OUT_W'(i);
      pred_last  = with_last && (i == n - 1);
      acc        = 1'b0;
      waited     = 0;
      while (!acc && waited <= 50) begin
        acc = pred_ready;
        tick();
        waited++;
      end
      if (!acc) begin
        chk("ready_timeout", 32'd0, 32'd1);
        i = n;
      end
    end
    pred_valid = 1'b0;
    pred_last  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin
      tick();
      c++;
    end
    chk("done_reached", done, 1);
  endtask

  task automatic chk_wlog(input string tag, input int n, input logic [OUT_W-1:0] d0);
    chk({tag, "_nwrites"}, wlog.size(), n);
    for (int i = 0; i < n && i < wlog.size(); i++)
      chk(tag, wlog[i], {ADDR_W'(BASE_ADDR + i), OUT_W'(d0 + OUT_W'(i))});
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    chk_on = 1'b1;
    chk("rst_mem_addr", mem_addr, BASE_ADDR);
    chk("rst_count", count, 0);

    // Beats offered before any start are ignored.
    pred_valid = 1'b1;
    pred_data  = 8'h7F;
    repeat (5) tick();
    pred_valid = 1'b0;
    chk("idle_no_write", wlog.size(), 0);

    // Continuous stream of five beats.
    pulse_start();
    wlog.delete();
    send(5, 8'h11, 1'b0, 0, 1'b1);
    wait_done(50);
    chk("t2_count", count, 5);
    chk("t2_ovf", overflow, 0);
    chk_wlog("t2_wr", 5, 8'h11);

    // Valid held while DONE must not be taken.
    pred_valid = 1'b1;
    pred_data  = 8'h7F;
    repeat (3) tick();
    pred_valid = 1'b0;

    // Gapped burst that exactly fills the address space.
    pulse_start();
    wlog.delete();
    send(8, 8'h30, 1'b0, 40, 1'b1);
    wait_done(100);
    chk("t3_count", count, 8);
    chk("t3_ovf", overflow, 0);
    chk_wlog("t3_wr", 8, 8'h30);

    // Beats beyond the last address are dropped.
    pulse_start();
    wlog.delete();
    send(11, 8'h50, 1'b0, 0, 1'b1);
    wait_done(100);
    chk("t4_count", count, NADDR);
    chk("t4_ovf", overflow, 1);
    chk_wlog("t4_wr", NADDR, 8'h50);

    // Restart mid-session with a beat offered in the start cycle.
    pulse_start();
    send(3, 8'h60, 1'b0, 0, 1'b0);
    pred_valid = 1'b1;
    pred_data  = 8'h99;
    pulse_start();
    pred_valid = 1'b0;
    wlog.delete();
    chk("t5_done_clr", done, 0);
    chk("t5_ovf_clr", overflow, 0);
    chk("t5_count_clr", count, 0);
    send(3, 8'hA0, 1'b0, 0, 1'b1);
    wait_done(50);
    chk("t5_count", count, 3);
    chk_wlog("t5_wr", 3, 8'hA0);

    // Asynchronous reset in the middle of a burst.
    pulse_start();
    pred_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pred_data = 8'hC0 + 8'(i);
      tick();
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_we", mem_we, 0);
    chk("arst_addr", mem_addr, BASE_ADDR);
    chk("arst_wdata", mem_wdata, 0);
    chk("arst_count", count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", pred_ready, 0);
    chk("arst_done", done, 0);
    chk("arst_ovf", overflow, 0);
    pred_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Random sessions of varying length and gap density.
    for (int s = 0; s < 20; s++) begin
      n = int'($urandom_range(1, 12));
      pulse_start();
      send(n, 8'h00, 1'b1, int'($urandom_range(0, 60)), 1'b1);
      wait_done(100);
      chk("rnd_count", count, (n < NADDR) ? n : NADDR);
      chk("rnd_ovf", overflow, n > NADDR);
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
